// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package Uart_Tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  localparam logic [1:0] TXDATA_OFF = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_W     = 5;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised; dout shows the head entry.
module tx_fifo
  import Uart_Tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push_s;
  logic             do_pop_s;

  // Fullness is judged before this edge's pop, so a push into a full FIFO is lost.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push_s && !do_pop_s) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (!do_push_s && do_pop_s) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == CNT_W'(0));
  assign count = cnt_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decoder, status register, TX FIFO and serialiser FSM.
module mmio_uart_tx
  import Uart_Tx_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1002_0000,
  parameter int                    CLK_PER_BIT = 434,
  parameter int                    FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ADDR_WIDTH-1:0] RWAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  Sel,
  output logic                  Tx,
  output logic                  TxIrq
);

  localparam int BAUD_W = $clog2(CLK_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e    state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic              hit_s, push_s, clr_ovf_s, pop_s, baud_last_s;
  logic [1:0]        off_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic [DATA_WIDTH-1:0] status_s;
  logic              unused_s;

  assign hit_s       = (RWAddress[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign off_s       = RWAddress[3:2];
  assign push_s      = MemWrite && hit_s && (off_s == TXDATA_OFF);
  assign clr_ovf_s   = MemWrite && hit_s && (off_s == STATUS_OFF);
  assign baud_last_s = (baud_q == BAUD_W'(CLK_PER_BIT - 1));
  // Reads have no side effects, so the load strobe is not needed by the decoder.
  assign unused_s    = ^{MemRead, RWAddress[1:0], WriteData[DATA_WIDTH-1:8]};

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_cnt_s)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty_s) begin
          state_d = START;
          pop_s   = 1'b1;
          shift_d = fifo_dout_s;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_last_s) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = 3'd0;
          end else begin
            state_d = DATA;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (baud_last_s) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty_s) begin
            state_d = START;
            pop_s   = 1'b1;
            shift_d = fifo_dout_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    if (push_s && fifo_full_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status_s = '0;
    status_s[STAT_BUSY_BIT]  = (state_q != IDLE);
    status_s[STAT_FULL_BIT]  = fifo_full_s;
    status_s[STAT_EMPTY_BIT] = fifo_empty_s;
    status_s[STAT_OVF_BIT]   = ovf_q;
    status_s[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_cnt_s);
    if (hit_s && (off_s == STATUS_OFF)) begin
      RdData = status_s;
    end else begin
      RdData = '0;
    end
  end

  assign Sel   = hit_s;
  assign Tx    = tx_q;
  assign TxIrq = fifo_empty_s && (state_q == IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-timeline reference model, decode table, corner sequences, random traffic.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h1002_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] RWAddress = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] RdData;
  logic        Sel, Tx, TxIrq;

  mmio_uart_tx #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .BASE_ADDR   (BASE),
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .RWAddress (RWAddress),
    .WriteData (WriteData),
    .RdData    (RdData),
    .Sel       (Sel),
    .Tx        (Tx),
    .TxIrq     (TxIrq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queued bytes, plus the frame currently on the line and the edge it started at.
  logic [7:0] mq[$];
  bit         active = 1'b0;
  int         cur_s = 0;
  logic [7:0] cur_b = 8'd0;
  bit         m_ovf = 1'b0;
  int         cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } dec_vec_t;
  dec_vec_t dv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'd0;
    s[0] = active;
    s[1] = (mq.size() == DEPTH);
    s[2] = (mq.size() == 0);
    s[3] = m_ovf;
    s[12:8] = 5'(mq.size());
    return s;
  endfunction

  function automatic logic m_tx();
    int k;
    if (!active) return 1'b1;
    k = (cyc - cur_s) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur_b[k-1];
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic hit;
    logic [1:0] off;
    int cnt_pre;
    cyc++;
    if (!rst) begin
      mq.delete();
      active = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    hit = (RWAddress[31:4] == BASE[31:4]);
    off = RWAddress[3:2];
    cnt_pre = mq.size();
    if (active && (cyc == cur_s + FRAME)) active = 1'b0;
    if (!active && (cnt_pre > 0)) begin
      cur_b = mq.pop_front();
      cur_s = cyc;
      active = 1'b1;
    end
    if (MemWrite && hit && (off == 2'd0)) begin
      if (cnt_pre < DEPTH) mq.push_back(WriteData[7:0]);
      else m_ovf = 1'b1;
    end
    if (MemWrite && hit && (off == 2'd1)) m_ovf = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("tx", 32'(Tx), 32'(m_tx()));
    chk("txirq", 32'(TxIrq), 32'((mq.size() == 0) && !active));
  endtask

  task automatic bus(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    logic esel;
    MemWrite = we;
    MemRead = re;
    RWAddress = a;
    WriteData = d;
    #1;
    esel = (a[31:4] == BASE[31:4]);
    chk("sel", 32'(Sel), 32'(esel));
    chk("rddata", RdData, (esel && (a[3:2] == 2'd1)) ? m_status() : 32'd0);
  endtask

  task automatic cycle(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    bus(we, re, a, d);
    step();
  endtask

  initial begin
    int lows;
    int r;
    int thr;

    dv[0] = '{32'h0000_0000, 1'b0, 32'd0};
    dv[1] = '{32'h1002_0000, 1'b1, 32'd0};
    dv[2] = '{32'h1002_0004, 1'b1, 32'h0000_0004};
    dv[3] = '{32'h1002_0007, 1'b1, 32'h0000_0004};
    dv[4] = '{32'h1002_0008, 1'b1, 32'd0};
    dv[5] = '{32'h1002_000C, 1'b1, 32'd0};
    dv[6] = '{32'h1003_0004, 1'b0, 32'd0};
    dv[7] = '{32'h1002_0014, 1'b0, 32'd0};

    // Reset and idle state
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk("reset_tx", 32'(Tx), 32'd1);
    chk("reset_irq", 32'(TxIrq), 32'd1);
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 1'b1, dv[i].addr, 32'd0);
      chk("dec_sel", 32'(Sel), 32'(dv[i].exp_sel));
      chk("dec_rd", RdData, dv[i].exp_rd);
      step();
    end
    cycle(1'b1, 1'b0, BASE + 32'h8, 32'h77);
    bus(1'b0, 1'b1, BASE + 32'h4, 32'd0);
    chk("reserved_write_ignored", RdData, 32'h0000_0004);
    step();

    // Single 0x55 frame: exact bit pattern, latency and length
    cycle(1'b1, 1'b0, BASE, 32'h55);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        bus(1'b0, 1'b1, BASE + 32'h4, 32'd0);
        chk("status_after_push", RdData, 32'h0000_0100);
        step();
      end else begin
        cycle(1'b0, 1'b0, 32'd0, 32'd0);
      end
      chk("frame55_bit", 32'(Tx), 32'(i % 2));
      repeat (3) cycle(1'b0, 1'b0, 32'd0, 32'd0);
    end
    chk("frame55_irq_in_stop", 32'(TxIrq), 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    chk("frame55_irq_after", 32'(TxIrq), 32'd1);

    // Three back-to-back frames
    cycle(1'b1, 1'b0, BASE, 32'hA1);
    cycle(1'b1, 1'b0, BASE, 32'h02);
    cycle(1'b1, 1'b0, BASE, 32'hFF);
    bus(1'b0, 1'b1, BASE + 32'h4, 32'd0);
    chk("b2b_count", (RdData >> 8) & 32'h1F, 32'd2);
    step();
    repeat (117) cycle(1'b0, 1'b0, 32'd0, 32'd0);
    chk("b2b_irq_in_last_stop", 32'(TxIrq), 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    chk("b2b_irq_after_120", 32'(TxIrq), 32'd1);

    // Overflow while a frame is active
    cycle(1'b1, 1'b0, BASE, 32'h3C);
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, BASE, 32'(8'h10 + i));
    bus(1'b0, 1'b1, BASE + 32'h4, 32'd0);
    chk("ovf_status", RdData, 32'h0000_040B);
    step();
    cycle(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    bus(1'b0, 1'b1, BASE + 32'h4, 32'd0);
    chk("ovf_cleared", RdData, 32'h0000_0403);
    step();
    repeat (5 * FRAME + 10) cycle(1'b0, 1'b0, 32'd0, 32'd0);
    chk("ovf_drained_irq", 32'(TxIrq), 32'd1);

    // Reset during data bit 3 with bytes still queued
    cycle(1'b1, 1'b0, BASE, 32'hC3);
    cycle(1'b1, 1'b0, BASE, 32'h5A);
    cycle(1'b1, 1'b0, BASE, 32'h81);
    repeat (16) cycle(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    chk("midreset_tx", 32'(Tx), 32'd1);
    bus(1'b0, 1'b1, BASE + 32'h4, 32'd0);
    chk("midreset_status", RdData, 32'h0000_0004);
    step();
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 32'd0);
      if (!Tx) lows++;
    end
    chk("midreset_no_frame", 32'(lows), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 1600; i++) begin
      r = int'($urandom_range(0, 99));
      thr = (i < 700) ? 30 : 3;
      if (r < thr) begin
        cycle(1'b1, 1'b0, BASE + 32'($urandom_range(0, 3)), $urandom);
      end else if (r < 35) begin
        cycle(1'b1, 1'b0, BASE + 32'h4, $urandom);
      end else if (r < 65) begin
        cycle(1'b0, 1'b1, BASE + 32'h4 + 32'($urandom_range(0, 3)), 32'd0);
      end else if (r < 70) begin
        cycle(1'b1, 1'b1, BASE + 32'h8 + 32'($urandom_range(0, 7)), $urandom);
      end else if (r < 71) begin
        rst = 1'b0;
        cycle(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
